ysyx_25050147_lsu_ctrl: RTL

Load/store sequencing controller between the execute stage and the data-memory port. It accepts one memory operation at a time and checks alignment. It drives a valid/ready request to memory, waits for the response, then extracts and extends the load data (byte/half/word, signed/unsigned) before handing the result to write-back. It is the block that owns and sequences the core's load-data extraction path.

---
 rtl/ysyx_25050147_lsu_ctrl_if.sv | 37 +++
 rtl/ysyx_25050147_lsu_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ysyx_25050147_lsu_ctrl_if.sv
// Handshake bundle between the execute stage, the LSU controller, the data memory and write-back.
// The slave modport is the controller's view; master is the surrounding pipeline/memory view.
interface ysyx_25050147_lsu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [2:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  modport slave (
    input  in_valid, in_wen, in_op, in_addr, in_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err, out_ready,
    output in_ready, mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    output out_valid, out_rdata, out_err
  );

  modport master (
    output in_valid, in_wen, in_op, in_addr, in_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err, out_ready,
    input  in_ready, mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
    input  out_valid, out_rdata, out_err
  );
endinterface

// File: rtl/ysyx_25050147_lsu_ctrl.sv
// Load/store sequencer: one operation at a time, alignment check, memory handshake,
// load-data extraction and extension. All outputs are registered.
module ysyx_25050147_lsu_ctrl (
  input  logic clk,
  input  logic rst,
  ysyx_25050147_lsu_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | ready to accept an operation
  // REQ   | memory request presented, waiting for mem_req_ready
  // WAIT  | request accepted, waiting for mem_rsp_valid
  // DONE  | result held for write-back until out_ready
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  logic        wen_q;
  logic [2:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Op size lives in op[1:0] for both loads and stores; 11 is never legal.
  always_comb begin
    illegal    = (bus.in_op[1:0] == 2'b11);
    misaligned = ((bus.in_op[1:0] == 2'b01) && bus.in_addr[0]) ||
                 ((bus.in_op[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));
    strb_n  = 4'b0000;
    wdata_n = 32'h0000_0000;
    if (bus.in_wen) begin
      case (bus.in_op[1:0])
        2'b00: begin
          strb_n  = 4'b0001 << bus.in_addr[1:0];
          wdata_n = {4{bus.in_wdata[7:0]}};
        end
        2'b01: begin
          strb_n  = 4'b0011 << bus.in_addr[1:0];
          wdata_n = {2{bus.in_wdata[15:0]}};
        end
        default: begin
          strb_n  = 4'b1111;
          wdata_n = bus.in_wdata;
        end
      endcase
    end
  end

  // op[2] selects zero extension; word ops pass through regardless.
  always_comb begin
    shifted = bus.mem_rsp_rdata >> {addr_lo_q, 3'b000};
    case (op_q[1:0])
      2'b00:   load_val = {{24{shifted[7]  & ~op_q[2]}}, shifted[7:0]};
      2'b01:   load_val = {{16{shifted[15] & ~op_q[2]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      wen_q             <= 1'b0;
      op_q              <= 3'b000;
      addr_lo_q         <= 2'b00;
      bus.in_ready      <= 1'b1;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= 32'h0;
      bus.mem_wen       <= 1'b0;
      bus.mem_wstrb     <= 4'b0000;
      bus.mem_wdata     <= 32'h0;
      bus.out_valid     <= 1'b0;
      bus.out_rdata     <= 32'h0;
      bus.out_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            wen_q        <= bus.in_wen;
            op_q         <= bus.in_op;
            addr_lo_q    <= bus.in_addr[1:0];
            bus.in_ready <= 1'b0;
            if (illegal || misaligned) begin
              bus.out_valid <= 1'b1;
              bus.out_err   <= 1'b1;
              bus.out_rdata <= 32'h0;
              state         <= DONE;
            end else begin
              bus.mem_req_valid <= 1'b1;
              bus.mem_addr      <= {bus.in_addr[31:2], 2'b00};
              bus.mem_wen       <= bus.in_wen;
              bus.mem_wstrb     <= strb_n;
              bus.mem_wdata     <= wdata_n;
              state             <= REQ;
            end
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            bus.mem_req_valid <= 1'b0;
            state             <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rsp_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_err   <= bus.mem_rsp_err;
            bus.out_rdata <= (bus.mem_rsp_err || wen_q) ? 32'h0 : load_val;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
